norm32: RTL and testbench

Multi-cycle 32-bit normalizer, the inverse companion of the ALU shift unit. Given an operand, it finds the left-shift amount that normalizes the operand and returns both the normalized value and that amount. `SRL` (logical mode) or `SRA` (arithmetic mode) of the result by the returned count restores the operand. It sits beside the shift unit in the EX stage and is used for count-leading-zeros / count-leading-sign instructions, with valid/ready handshakes on both sides.

---
 rtl/norm32_pkg.sv | 29 ++
 rtl/norm32_if.sv | 24 ++
 rtl/norm32_step.sv | 36 +++
 rtl/norm32.sv | 85 ++++++++
 tb/tb_norm32.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/norm32_pkg.sv
// Shared definitions for the 32-bit normalizer: mode constants, FSM state
// encoding and the per-step shift-width table.
// Latency: n/a (package).  Backpressure: n/a (package).
package norm32_pkg;

  localparam logic NORM_LOGICAL = 1'b0;
  localparam logic NORM_ARITH   = 1'b1;

  localparam int          NUM_STEPS = 5;
  localparam logic [2:0]  LAST_STEP = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Binary-search widths; element 0 is the first step (16).
  localparam logic [NUM_STEPS-1:0][5:0] STEP_WIDTH =
    {6'd1, 6'd2, 6'd4, 6'd8, 6'd16};

  function automatic logic [5:0] step_width(input logic [2:0] idx);
    logic [5:0] w;
    w = 6'd0;
    if (idx <= LAST_STEP) w = STEP_WIDTH[idx];
    return w;
  endfunction

endpackage

// File: rtl/norm32_if.sv
// Operand/result handshake bundle for norm32.
// Latency: n/a (wires only).  Backpressure: valid/ready on both sides.
// master = operand producer / result consumer, slave = the normalizer.
interface norm32_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic        in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [5:0]  out_count;
  logic        out_zero;

  modport master (
    output in_valid, in_a, in_mode, out_ready,
    input  in_ready, out_valid, out_result, out_count, out_zero
  );

  modport slave (
    input  in_valid, in_a, in_mode, out_ready,
    output in_ready, out_valid, out_result, out_count, out_zero
  );
endinterface

// File: rtl/norm32_step.sv
// One binary-search normalization step: shift by w if the top bits are redundant.
// Latency: combinational.  Backpressure: none (pure function).
// Ports: value/mode/step_idx in; next_value and amount (0 or w) out.
module norm32_step
  import norm32_pkg::*;
(
  input  logic [31:0] value,
  input  logic        mode,
  input  logic [2:0]  step_idx,
  output logic [31:0] next_value,
  output logic [5:0]  amount
);

  logic [5:0]  w;
  logic [31:0] test_bits;
  logic [31:0] top_mask;

  always_comb begin
    w          = step_width(step_idx);
    test_bits  = value;
    top_mask   = ~(32'hFFFF_FFFF >> w);
    next_value = value;
    amount     = 6'd0;
    if (mode == NORM_ARITH) begin
      // Bits equal to the sign become 0 after the XOR; the sign bit itself
      // is part of the window, hence w+1.
      test_bits = value ^ {32{value[31]}};
      top_mask  = ~(32'hFFFF_FFFF >> (w + 6'd1));
    end
    if ((test_bits & top_mask) == 32'd0) begin
      next_value = value << w;
      amount     = w;
    end
  end

endmodule

// File: rtl/norm32.sv
// Multi-cycle 32-bit normalizer (CLZ / CLS) with valid/ready on both sides.
// Latency: accept edge t -> out_valid after edge t+5; one op in flight.
// Backpressure: result held in DONE until out_ready; in_ready low meanwhile.
// Ports: clk, reset_n (async, active low), bus (norm32_if.slave).
module norm32
  import norm32_pkg::*;
(
  input  logic     clk,
  input  logic     reset_n,
  norm32_if.slave  bus
);

  state_t      state, state_n;
  logic [2:0]  step_idx;
  logic [31:0] work;
  logic [5:0]  count;
  logic        zero;
  logic        mode;

  logic [31:0] step_value;
  logic [5:0]  step_amount;

  norm32_step u_step (
    .value      (work),
    .mode       (mode),
    .step_idx   (step_idx),
    .next_value (step_value),
    .amount     (step_amount)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.in_valid)          state_n = CALC;
      CALC:    if (step_idx == LAST_STEP) state_n = DONE;
      DONE:    if (bus.out_ready)         state_n = IDLE;
      default:                            state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      step_idx <= 3'd0;
      work     <= 32'd0;
      count    <= 6'd0;
      zero     <= 1'b0;
      mode     <= NORM_LOGICAL;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            work     <= bus.in_a;
            mode     <= bus.in_mode;
            zero     <= (bus.in_a == 32'd0);
            count    <= 6'd0;
            step_idx <= 3'd0;
          end
        end
        CALC: begin
          work     <= step_value;
          step_idx <= step_idx + 3'd1;
          // A zero operand in logical mode has 32 leading zeros, but the
          // 16+8+4+2+1 search can only reach 31.
          if (step_idx == LAST_STEP && zero && mode == NORM_LOGICAL)
            count <= 6'd32;
          else
            count <= count + step_amount;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready   = (state == IDLE);
  assign bus.out_valid  = (state == DONE);
  assign bus.out_result = work;
  assign bus.out_count  = count;
  assign bus.out_zero   = zero;

endmodule

// File: tb/tb_norm32.sv
module tb_norm32;
  import norm32_pkg::*;

  logic clk;
  logic reset_n;
  norm32_if io ();

  norm32 dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: count the leading bits directly from the definition.
  function automatic void ref_norm(input logic [31:0] a, input logic m,
                                   output logic [31:0] r, output int c);
    int n;
    n = 0;
    if (m == NORM_LOGICAL) begin
      while (n < 32 && a[31-n] == 1'b0) n++;
      c = n;
    end else begin
      while (n < 32 && a[31-n] == a[31]) n++;
      c = n - 1;
    end
    r = (c >= 32) ? 32'd0 : (a << c);
  endfunction

  task automatic run_op(input logic [31:0] a, input logic m, input int hold,
                        output logic [31:0] r, output logic [5:0] c,
                        output logic z, output int lat);
    int w;
    w = 0;
    while (!io.in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("in_ready_before_op", {31'd0, io.in_ready}, 32'd1);
    io.in_valid = 1'b1;
    io.in_a     = a;
    io.in_mode  = m;
    @(posedge clk);
    @(negedge clk);
    io.in_valid = 1'b0;
    io.in_a     = $urandom;
    io.in_mode  = 1'($urandom);
    lat = 0;
    while (!io.out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    r = io.out_result;
    c = io.out_count;
    z = io.out_zero;
    repeat (hold) @(negedge clk);
    io.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    io.out_ready = 1'b0;
  endtask

  typedef struct {
    logic [31:0] a;
    logic        mode;
    logic [31:0] exp_res;
    logic [5:0]  exp_cnt;
    logic        exp_zero;
  } vec_t;

  initial begin
    vec_t        vecs[10];
    logic [31:0] r, exp_r, hold_r;
    logic [5:0]  c, hold_c;
    logic        z;
    int          lat, exp_c;

    vecs[0] = '{32'h0001_0000, NORM_LOGICAL, 32'h8000_0000, 6'd15, 1'b0};
    vecs[1] = '{32'hFFFF_8000, NORM_ARITH,   32'h8000_0000, 6'd16, 1'b0};
    vecs[2] = '{32'h0000_0001, NORM_ARITH,   32'h4000_0000, 6'd30, 1'b0};
    vecs[3] = '{32'h0000_0001, NORM_LOGICAL, 32'h8000_0000, 6'd31, 1'b0};
    vecs[4] = '{32'h0000_0000, NORM_LOGICAL, 32'h0000_0000, 6'd32, 1'b1};
    vecs[5] = '{32'h0000_0000, NORM_ARITH,   32'h0000_0000, 6'd31, 1'b1};
    vecs[6] = '{32'hFFFF_FFFF, NORM_ARITH,   32'h8000_0000, 6'd31, 1'b0};
    vecs[7] = '{32'h8000_0000, NORM_LOGICAL, 32'h8000_0000, 6'd0,  1'b0};
    vecs[8] = '{32'h8000_0000, NORM_ARITH,   32'h8000_0000, 6'd0,  1'b0};
    vecs[9] = '{32'h4000_0000, NORM_ARITH,   32'h4000_0000, 6'd0,  1'b0};

    // Reset with in_valid asserted: must be ignored.
    reset_n      = 1'b0;
    io.in_valid  = 1'b1;
    io.in_a      = 32'h1234_5678;
    io.in_mode   = NORM_LOGICAL;
    io.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready",  {31'd0, io.in_ready},  32'd1);
    chk("rst_out_valid", {31'd0, io.out_valid}, 32'd0);
    chk("rst_result",    io.out_result,         32'd0);
    chk("rst_count",     {26'd0, io.out_count}, 32'd0);
    chk("rst_zero",      {31'd0, io.out_zero},  32'd0);
    io.in_valid = 1'b0;
    reset_n     = 1'b1;
    @(negedge clk);

    // Directed table.
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].mode, i % 3, r, c, z, lat);
      chk($sformatf("vec%0d_result", i), r, vecs[i].exp_res);
      chk($sformatf("vec%0d_count", i), {26'd0, c}, {26'd0, vecs[i].exp_cnt});
      chk($sformatf("vec%0d_zero", i), {31'd0, z}, {31'd0, vecs[i].exp_zero});
      chk($sformatf("vec%0d_latency", i), lat, 32'd5);
    end

    // Backpressure: hold DONE for 10 cycles while a new operand is offered.
    io.in_valid = 1'b1;
    io.in_a     = 32'h0001_0000;
    io.in_mode  = NORM_LOGICAL;
    @(posedge clk);
    @(negedge clk);
    io.in_a = 32'h0000_00FF;
    lat = 0;
    while (!io.out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk("bp_latency", lat, 32'd5);
    hold_r = io.out_result;
    hold_c = io.out_count;
    chk("bp_result", hold_r, 32'h8000_0000);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_out_valid", {31'd0, io.out_valid}, 32'd1);
      chk("bp_in_ready",  {31'd0, io.in_ready},  32'd0);
      chk("bp_result_stable", io.out_result, hold_r);
      chk("bp_count_stable", {26'd0, io.out_count}, {26'd0, hold_c});
    end
    io.in_valid  = 1'b0;
    io.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    io.out_ready = 1'b0;
    chk("bp_in_ready_after", {31'd0, io.in_ready},  32'd1);
    chk("bp_out_valid_after", {31'd0, io.out_valid}, 32'd0);

    // Reset in CALC at step 2.
    io.in_valid = 1'b1;
    io.in_a     = 32'h0000_1234;
    io.in_mode  = NORM_LOGICAL;
    @(posedge clk);
    @(negedge clk);
    io.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_in_ready",  {31'd0, io.in_ready},  32'd1);
    chk("mid_rst_out_valid", {31'd0, io.out_valid}, 32'd0);
    chk("mid_rst_result",    io.out_result,         32'd0);
    chk("mid_rst_count",     {26'd0, io.out_count}, 32'd0);
    chk("mid_rst_zero",      {31'd0, io.out_zero},  32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("post_rst_no_valid", {31'd0, io.out_valid}, 32'd0);
    end
    run_op(32'h8000_0000, NORM_LOGICAL, 0, r, c, z, lat);
    chk("post_rst_result", r, 32'h8000_0000);
    chk("post_rst_count", {26'd0, c}, 32'd0);
    chk("post_rst_latency", lat, 32'd5);

    // Random sweep in both modes against the reference model.
    for (int n = 0; n < 2000; n++) begin
      logic [31:0] a;
      logic        m;
      m = 1'($urandom);
      a = $urandom;
      case ($urandom_range(0, 3))
        0: a = a >> $urandom_range(0, 31);
        1: a = 32'($signed(a) >>> $urandom_range(0, 31));
        2: a = (n % 2 == 0) ? 32'd0 : 32'hFFFF_FFFF;
        default: ;
      endcase
      ref_norm(a, m, exp_r, exp_c);
      run_op(a, m, $urandom_range(0, 2), r, c, z, lat);
      chk("rnd_result", r, exp_r);
      chk("rnd_count", {26'd0, c}, exp_c);
      chk("rnd_zero", {31'd0, z}, {31'd0, (a == 32'd0)});
      chk("rnd_latency", lat, 32'd5);
      if (m == NORM_LOGICAL) begin
        if (a != 32'd0) chk("rnd_inv_logical", r >> c, a);
      end else begin
        chk("rnd_inv_arith", 32'($signed(r) >>> c), a);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
